mor1kx_tt_spr_arbiter: RTL and testbench
========================================

# mor1kx_tt_spr_arbiter

Shares the tick-timer SPR slave port between two masters: the core SPR port (CPU `mtspr`/`mfspr`) and the debug unit SPR port. It serialises accesses with a three-state FSM, registers the winner's command, and enforces a bounded wait on the timer's acknowledge. It returns registered read data, or a timeout error, to the originating master only. It sits between the core/debug SPR fabrics and the tick timer's SPR bus interface.

## Interface
- TIMEOUT, 15: cycles in XFER without `tt_ack_i` before the access is aborted; legal range 1..255.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- core_req_i  in  1  core access request, held until `core_ack_o`
- core_we_i  in  1  core write enable
- core_addr_i  in  16  core SPR address
- core_dat_i  in  32  core write data
- core_ack_o  out  1  one-cycle completion pulse to core
- core_dat_o  out  32  read data, valid only while `core_ack_o` is high
- dbg_req_i, dbg_we_i, dbg_addr_i, dbg_dat_i  in  1/1/16/32  debug master, same semantics as the core master
- dbg_ack_o, dbg_dat_o  out  1/32  debug completion and read data
- tt_access_o  out  1  tick-timer SPR access strobe
- tt_we_o  out  1  write enable to timer
- tt_addr_o  out  16  address to timer
- tt_dat_o  out  32  write data to timer
- tt_ack_i  in  1  timer acknowledge
- tt_dat_i  in  32  timer read data
- err_o  out  1  sticky timeout flag
- err_clr_i  in  1  clears `err_o`
- grant_dbg_o  out  1  1 when the current or last grant is debug

## Operation
- FSM states:
  - **IDLE**: if any request is high, latch the winner's we/addr/dat into command registers, record the winner, clear the wait counter, and go to XFER. Otherwise stay in IDLE.
  - **XFER**: drive `tt_access_o`=1 with the latched command; the counter increments each cycle.
    - If `tt_ack_i`=1: capture `tt_dat_i` into the response register (0 if it is a write) and go to RESP.
    - Else if the counter equals TIMEOUT-1: load 0 into the response register, set `err_o`, and go to RESP.
  - **RESP**: pulse the winner's `*_ack_o` for exactly one cycle, drive the response register on the winner's `*_dat_o`, then go to IDLE.
- The loser's ack and data stay at 0 at all times.
- Non-granted `*_dat_o` is 0.
- `tt_*` outputs are 0 outside XFER.
- Master rule: a master deasserts `req` at the clock edge that ends its ack cycle.
  - The arbiter does not re-sample a request during RESP.
  - A req still high in IDLE is treated as a new access.
- Counter is 8 bits and saturates; it never wraps during XFER.
- `err_o` is set by a timeout and cleared by `err_clr_i`. If both occur in the same cycle, set wins.
- Master inputs change freely outside IDLE; only the latched copy is used.
- `grant_dbg_o` updates on the IDLE→XFER transition.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0; last-grant register = debug, so the core wins the first contention.
- Reset mid-XFER or mid-RESP: the FSM returns to IDLE next cycle, no ack is issued, and the pending access is dropped.
- Latency, request seen at edge N in IDLE:
  - `tt_access_o` is high in cycle N+1.
  - With `tt_ack_i` in that same cycle, the master ack arrives in cycle N+2.
  - Minimum request-to-ack is 2 cycles.
  - Back-to-back accesses from one master occur at most every 3 cycles.
- Timeout with no `tt_ack_i`: XFER lasts exactly TIMEOUT cycles, and the ack arrives TIMEOUT+1 cycles after the request edge.
- `tt_ack_i` in the same cycle the timeout would fire: ack wins, no error.
- `tt_ack_i` outside XFER is ignored.

## Configuration
- `MOR1KX_TT_ARB_RR_EN`
  - Defined: round-robin. When both requests are high in IDLE, grant the master not recorded in the last-grant register. The single-requester case is unaffected.
  - Undefined: fixed priority, core always wins over debug. The last-grant register is still maintained, for `grant_dbg_o` only.

## Test plan
- Core write: addr 0x5000, data 0x4000_0010, timer acks in the first XFER cycle -> `tt_we_o`=1 for one cycle with matching addr/data; `core_ack_o` 2 cycles after the request; `dbg_ack_o` stays 0.
- Debug read: timer returns 0x0000_1234 -> `dbg_ack_o` pulse with `dbg_dat_o`=0x0000_1234; `core_dat_o`=0 throughout.
- Simultaneous requests held continuously, 4 accesses -> with `_RR_EN` grants alternate core, dbg, core, dbg; without it, all core grants are serviced before debug.
- TIMEOUT=15 and the timer never acks -> `tt_access_o` high exactly 15 cycles; ack with data 0; `err_o`=1; `err_o` clears after an `err_clr_i` pulse.
- `tt_ack_i` coincides with cycle 15 of XFER -> normal completion, `err_o` stays 0.
- `rst` asserted in the second XFER cycle -> no master ack, all outputs 0 next cycle; a fresh core request completes normally afterwards.

Source files
------------

// File: rtl/mor1kx_tt_spr_arbiter.sv
`default_nettype none
// ============================================================================
// mor1kx_tt_spr_arbiter
//   Shares the tick-timer SPR slave port between the core and debug masters.
//   Optional: MOR1KX_TT_ARB_RR_EN selects round-robin instead of core priority.
//   Revision: 1.0
// ============================================================================
module mor1kx_tt_spr_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [15:0] core_addr_i,
  input  logic [31:0] core_dat_i,
  output logic        core_ack_o,
  output logic [31:0] core_dat_o,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [15:0] dbg_addr_i,
  input  logic [31:0] dbg_dat_i,
  output logic        dbg_ack_o,
  output logic [31:0] dbg_dat_o,
  output logic        tt_access_o,
  output logic        tt_we_o,
  output logic [15:0] tt_addr_o,
  output logic [31:0] tt_dat_o,
  input  logic        tt_ack_i,
  input  logic [31:0] tt_dat_i,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic        grant_dbg_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        win_dbg;
  logic        last_dbg;
  logic        pick_dbg;
  logic        any_req;
  logic        to_fire;
  logic        xfer_done;
  logic [31:0] resp_data;

`ifdef MOR1KX_TT_ARB_RR_EN
  assign pick_dbg = dbg_req_i & (~core_req_i | ~last_dbg);
`else
  assign pick_dbg = dbg_req_i & ~core_req_i;
`endif

  assign any_req   = core_req_i | dbg_req_i;
  // An acknowledge in the final wait cycle takes precedence over the timeout.
  assign to_fire   = (state == XFER) & ~tt_ack_i & (cnt == TMO_LAST);
  assign xfer_done = (state == XFER) & (tt_ack_i | to_fire);
  assign resp_data = (tt_ack_i & ~tt_we_o) ? tt_dat_i : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      win_dbg     <= 1'b0;
      last_dbg    <= 1'b1;
      grant_dbg_o <= 1'b0;
      tt_access_o <= 1'b0;
      tt_we_o     <= 1'b0;
      tt_addr_o   <= 16'd0;
      tt_dat_o    <= 32'd0;
      core_ack_o  <= 1'b0;
      core_dat_o  <= 32'd0;
      dbg_ack_o   <= 1'b0;
      dbg_dat_o   <= 32'd0;
      err_o       <= 1'b0;
    end else begin
      core_ack_o <= 1'b0;
      core_dat_o <= 32'd0;
      dbg_ack_o  <= 1'b0;
      dbg_dat_o  <= 32'd0;
      err_o      <= to_fire | (err_o & ~err_clr_i);

      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= XFER;
            cnt         <= 8'd0;
            win_dbg     <= pick_dbg;
            last_dbg    <= pick_dbg;
            grant_dbg_o <= pick_dbg;
            tt_access_o <= 1'b1;
            tt_we_o     <= pick_dbg ? dbg_we_i   : core_we_i;
            tt_addr_o   <= pick_dbg ? dbg_addr_i : core_addr_i;
            tt_dat_o    <= pick_dbg ? dbg_dat_i  : core_dat_i;
          end
        end

        XFER: begin
          if (cnt != 8'hFF)
            cnt <= cnt + 8'd1;
          if (xfer_done) begin
            state       <= RESP;
            tt_access_o <= 1'b0;
            tt_we_o     <= 1'b0;
            tt_addr_o   <= 16'd0;
            tt_dat_o    <= 32'd0;
            if (win_dbg) begin
              dbg_ack_o <= 1'b1;
              dbg_dat_o <= resp_data;
            end else begin
              core_ack_o <= 1'b1;
              core_dat_o <= resp_data;
            end
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mor1kx_tt_spr_arbiter.sv
`default_nettype none
// Directed self-checking bench for mor1kx_tt_spr_arbiter (TIMEOUT = 15).
module tb_mor1kx_tt_spr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req_i = 1'b0, core_we_i = 1'b0;
  logic [15:0] core_addr_i = '0;
  logic [31:0] core_dat_i = '0;
  logic        core_ack_o;
  logic [31:0] core_dat_o;
  logic        dbg_req_i = 1'b0, dbg_we_i = 1'b0;
  logic [15:0] dbg_addr_i = '0;
  logic [31:0] dbg_dat_i = '0;
  logic        dbg_ack_o;
  logic [31:0] dbg_dat_o;
  logic        tt_access_o, tt_we_o;
  logic [15:0] tt_addr_o;
  logic [31:0] tt_dat_o;
  logic        tt_ack_i = 1'b0;
  logic [31:0] tt_dat_i = '0;
  logic        err_o;
  logic        err_clr_i = 1'b0;
  logic        grant_dbg_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mor1kx_tt_spr_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_dat_i(core_dat_i), .core_ack_o(core_ack_o), .core_dat_o(core_dat_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_dat_i(dbg_dat_i), .dbg_ack_o(dbg_ack_o), .dbg_dat_o(dbg_dat_o),
    .tt_access_o(tt_access_o), .tt_we_o(tt_we_o), .tt_addr_o(tt_addr_o),
    .tt_dat_o(tt_dat_o), .tt_ack_i(tt_ack_i), .tt_dat_i(tt_dat_i),
    .err_o(err_o), .err_clr_i(err_clr_i), .grant_dbg_o(grant_dbg_o)
  );

  wire [117:0] all_outs = {core_ack_o, core_dat_o, dbg_ack_o, dbg_dat_o, tt_access_o,
                           tt_we_o, tt_addr_o, tt_dat_o, err_o, grant_dbg_o};

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; core_req_i = 0; dbg_req_i = 0; tt_ack_i = 0; err_clr_i = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (all_outs !== 118'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", all_outs);
    end
    // Acknowledge outside XFER must be ignored.
    tt_ack_i = 1'b1; tt_dat_i = 32'hFFFF_FFFF;
    @(negedge clk);
    tt_ack_i = 1'b0;
    @(negedge clk);
    total++;
    if (all_outs !== 118'd0) begin
      bad++; $display("FAIL idle_ack_ignored got=%h exp=0", all_outs);
    end
  endtask

  task automatic test_core_write();
    core_req_i = 1; core_we_i = 1; core_addr_i = 16'h5000; core_dat_i = 32'h4000_0010;
    @(negedge clk);
    total++;
    if ({tt_access_o, tt_we_o, tt_addr_o, tt_dat_o, core_ack_o} !== {1'b1, 1'b1, 16'h5000, 32'h4000_0010, 1'b0}) begin
      bad++; $display("FAIL core_wr_cmd got acc=%b we=%b addr=%h dat=%h ack=%b exp 1 1 5000 40000010 0",
                      tt_access_o, tt_we_o, tt_addr_o, tt_dat_o, core_ack_o);
    end
    tt_ack_i = 1; tt_dat_i = 32'hDEAD_BEEF;
    core_addr_i = 16'h1111; core_dat_i = 32'h0;  // must not disturb the latched command
    @(negedge clk);
    total++;
    if ({core_ack_o, core_dat_o, dbg_ack_o, tt_access_o, tt_we_o, grant_dbg_o} !== {1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL core_wr_ack got ack=%b dat=%h dack=%b acc=%b we=%b gdbg=%b exp 1 0 0 0 0 0",
                      core_ack_o, core_dat_o, dbg_ack_o, tt_access_o, tt_we_o, grant_dbg_o);
    end
    core_req_i = 0; tt_ack_i = 0;
    @(negedge clk);
    total++;
    if ({core_ack_o, tt_access_o} !== 2'b00) begin
      bad++; $display("FAIL core_wr_single got ack=%b acc=%b exp 0 0", core_ack_o, tt_access_o);
    end
  endtask

  task automatic test_dbg_read();
    dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 16'h5001; dbg_dat_i = 32'h5555_5555;
    @(negedge clk);
    total++;
    if ({tt_access_o, tt_we_o, tt_addr_o} !== {1'b1, 1'b0, 16'h5001}) begin
      bad++; $display("FAIL dbg_rd_cmd got acc=%b we=%b addr=%h exp 1 0 5001", tt_access_o, tt_we_o, tt_addr_o);
    end
    tt_ack_i = 1; tt_dat_i = 32'h0000_1234;
    @(negedge clk);
    total++;
    if ({dbg_ack_o, dbg_dat_o, core_ack_o, core_dat_o, grant_dbg_o} !== {1'b1, 32'h0000_1234, 1'b0, 32'd0, 1'b1}) begin
      bad++; $display("FAIL dbg_rd_ack got ack=%b dat=%h cack=%b cdat=%h gdbg=%b exp 1 00001234 0 0 1",
                      dbg_ack_o, dbg_dat_o, core_ack_o, core_dat_o, grant_dbg_o);
    end
    dbg_req_i = 0; tt_ack_i = 0;
    @(negedge clk);
    total++;
    if ({dbg_ack_o, dbg_dat_o, grant_dbg_o} !== {1'b0, 32'd0, 1'b1}) begin
      bad++; $display("FAIL dbg_rd_after got ack=%b dat=%h gdbg=%b exp 0 0 1", dbg_ack_o, dbg_dat_o, grant_dbg_o);
    end
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_dbg;
    int core_left, dbg_left, seen;
    logic who;
`ifdef MOR1KX_TT_ARB_RR_EN
    exp_dbg = 4'b1010;  // bit i = grant i is debug: core, dbg, core, dbg
`else
    exp_dbg = 4'b1100;  // core, core, dbg, dbg
`endif
    apply_reset();
    core_left = 2; dbg_left = 2;
    core_req_i = 1; core_we_i = 0; core_addr_i = 16'h0001;
    dbg_req_i = 1;  dbg_we_i = 0;  dbg_addr_i = 16'h0002;
    for (int i = 0; i < 4; i++) begin
      seen = 0;
      for (int c = 0; c < 6 && seen == 0; c++) begin
        @(negedge clk);
        if (tt_access_o) seen = 1;
      end
      total++;
      if (seen == 0) begin
        bad++; $display("FAIL arb_wait_%0d got no access within bound", i);
      end else begin
        who = (tt_addr_o == 16'h0002);
        tt_ack_i = 1; tt_dat_i = 32'h100 + i;
        @(negedge clk);
        tt_ack_i = 0;
        total++;
        if ({who, grant_dbg_o, dbg_ack_o, core_ack_o} !== {exp_dbg[i], exp_dbg[i], exp_dbg[i], ~exp_dbg[i]}) begin
          bad++; $display("FAIL arb_grant_%0d got who=%b gdbg=%b dack=%b cack=%b exp dbg=%b",
                          i, who, grant_dbg_o, dbg_ack_o, core_ack_o, exp_dbg[i]);
        end
        if (who) begin dbg_left--; if (dbg_left == 0) dbg_req_i = 0; end
        else begin core_left--; if (core_left == 0) core_req_i = 0; end
      end
    end
    core_req_i = 0; dbg_req_i = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int acc, ack_at;
    logic [31:0] d;
    logic e;
    apply_reset();
    acc = 0; ack_at = 0; d = 32'hX; e = 1'b0;
    core_req_i = 1; core_we_i = 0; core_addr_i = 16'h5002;
    for (int i = 1; i <= 40 && ack_at == 0; i++) begin
      @(negedge clk);
      if (tt_access_o) acc++;
      if (core_ack_o) begin ack_at = i; d = core_dat_o; e = err_o; end
    end
    core_req_i = 0;
    total++;
    if ({acc, ack_at} !== {32'd15, 32'd16}) begin
      bad++; $display("FAIL timeout_len got access=%0d ack_at=%0d exp 15 16", acc, ack_at);
    end
    total++;
    if ({d, e} !== {32'd0, 1'b1}) begin
      bad++; $display("FAIL timeout_resp got dat=%h err=%b exp 0 1", d, e);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (err_o !== 1'b1) begin
      bad++; $display("FAIL err_sticky got %b exp 1", err_o);
    end
    err_clr_i = 1;
    @(negedge clk);
    err_clr_i = 0;
    total++;
    if (err_o !== 1'b0) begin
      bad++; $display("FAIL err_clear got %b exp 0", err_o);
    end
  endtask

  task automatic test_ack_at_limit();
    core_req_i = 1; core_we_i = 0; core_addr_i = 16'h5003;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 15) begin tt_ack_i = 1; tt_dat_i = 32'hA5A5_0F0F; end
    end
    total++;
    if (tt_access_o !== 1'b1) begin
      bad++; $display("FAIL limit_access got %b exp 1", tt_access_o);
    end
    @(negedge clk);
    tt_ack_i = 0; core_req_i = 0;
    total++;
    if ({core_ack_o, core_dat_o, err_o} !== {1'b1, 32'hA5A5_0F0F, 1'b0}) begin
      bad++; $display("FAIL limit_ack got ack=%b dat=%h err=%b exp 1 a5a50f0f 0", core_ack_o, core_dat_o, err_o);
    end
    @(negedge clk);
    total++;
    if (err_o !== 1'b0) begin
      bad++; $display("FAIL limit_noerr got %b exp 0", err_o);
    end
  endtask

  task automatic test_rst_mid_xfer();
    logic any_ack;
    core_req_i = 1; core_we_i = 1; core_addr_i = 16'h5004; core_dat_i = 32'h77;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0; core_req_i = 0;
    total++;
    if (all_outs !== 118'd0) begin
      bad++; $display("FAIL rst_mid_outputs got=%h exp=0", all_outs);
    end
    any_ack = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      any_ack |= core_ack_o | dbg_ack_o | tt_access_o;
    end
    total++;
    if (any_ack !== 1'b0) begin
      bad++; $display("FAIL rst_mid_dropped got activity=%b exp 0", any_ack);
    end
    core_req_i = 1; core_we_i = 0; core_addr_i = 16'h5005;
    @(negedge clk);
    tt_ack_i = 1; tt_dat_i = 32'h0BAD_F00D;
    @(negedge clk);
    tt_ack_i = 0; core_req_i = 0;
    total++;
    if ({core_ack_o, core_dat_o} !== {1'b1, 32'h0BAD_F00D}) begin
      bad++; $display("FAIL rst_fresh_access got ack=%b dat=%h exp 1 0badf00d", core_ack_o, core_dat_o);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_core_write();
    test_dbg_read();
    test_arbitration();
    test_timeout();
    test_ack_at_limit();
    test_rst_mid_xfer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
